// File: rtl/counter_timer_n.sv
// counter_timer_n: prescaled timer/counter with CTC and PWM modes behind a byte-wide register window.
// Define COUNTER_TIMER_N_UPDOWN_EN to enable up-down PWM in mode 11 (otherwise mode 11 acts as idle).
module counter_timer_n #(
  parameter logic [7:0]  BASE_ADDRESS = 8'h00,
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CHANNELS     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          din,
  input  logic [7:0]          address,
  input  logic                w_en,
  input  logic                r_en,
  output logic [7:0]          dout,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] out_en,
  output logic                irq
);
  localparam int unsigned NF   = CHANNELS + 1;
  localparam bit          WIDE = (WIDTH == 16);

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_CTC   = 2'b01,
    MODE_FPWM  = 2'b10,
    MODE_UDPWM = 2'b11
  } mode_t;

  // Storage is always 16 bits wide; high bytes stay zero when WIDTH is 8.
  mode_t               mode, mode_n, mode_eff;
  logic [15:0]         scale, scale_n, presc, presc_n;
  logic [15:0]         top_a, top_a_n, top_b, top_b_n, cnt, cnt_n, nxt;
  logic [15:0]         cmp_a   [CHANNELS];
  logic [15:0]         cmp_a_n [CHANNELS];
  logic [15:0]         cmp_b   [CHANNELS];
  logic [15:0]         cmp_b_n [CHANNELS];
  logic [NF-1:0]       oen, oen_n, ien, ien_n, flags, flags_n, fset, fclr;
  logic [CHANNELS-1:0] out_n;
  logic [7:0]          shadow, shadow_n, dout_n, rdata, off;
  logic                tick, clr_presc, mode_chg, load, wrap, irq_n;
`ifdef COUNTER_TIMER_N_UPDOWN_EN
  logic                dir, dir_n, up;
`endif

  assign off    = address - BASE_ADDRESS;
  assign out_en = oen[CHANNELS-1:0];

  // Next-state: bus writes, read mux, prescaler, counter and compare logic.
  always_comb begin
    mode_n    = mode;
    scale_n   = scale;
    presc_n   = presc;
    top_a_n   = top_a;
    top_b_n   = top_b;
    cnt_n     = cnt;
    nxt       = cnt;
    oen_n     = oen;
    ien_n     = ien;
    out_n     = out;
    shadow_n  = shadow;
    dout_n    = dout;
    rdata     = 8'h00;
    fset      = '0;
    fclr      = '0;
    clr_presc = 1'b0;
    mode_chg  = 1'b0;
    load      = 1'b0;
    wrap      = 1'b0;
`ifdef COUNTER_TIMER_N_UPDOWN_EN
    dir_n     = dir;
    up        = 1'b1;
`endif
    for (int i = 0; i < CHANNELS; i++) begin
      cmp_a_n[i] = cmp_a[i];
      cmp_b_n[i] = cmp_b[i];
    end

    mode_eff = mode;
`ifndef COUNTER_TIMER_N_UPDOWN_EN
    if (mode == MODE_UDPWM) mode_eff = MODE_IDLE;
`endif

    if (w_en) begin
      case (off)
        8'd0: begin scale_n[7:0] = din; clr_presc = 1'b1; end
        8'd1: if (WIDE) begin scale_n[15:8] = din; clr_presc = 1'b1; end
        8'd2: begin
          mode_n = mode_t'(din[1:0]);
          if (mode_t'(din[1:0]) != mode) mode_chg = 1'b1;
        end
        8'd3: oen_n = din[NF-1:0];
        8'd4: ien_n = din[NF-1:0];
        8'd5: fclr  = din[NF-1:0];
        8'd6: top_b_n[7:0] = din;
        8'd7: if (WIDE) top_b_n[15:8] = din;
        default: begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (off == 8'(10 + 2 * i)) cmp_b_n[i][7:0] = din;
            if (WIDE && off == 8'(11 + 2 * i)) cmp_b_n[i][15:8] = din;
          end
        end
      endcase
    end

    case (off)
      8'd0: rdata = scale[7:0];
      8'd1: rdata = WIDE ? scale[15:8] : 8'h00;
      8'd2: rdata = {6'd0, mode};
      8'd3: rdata = 8'(oen);
      8'd4: rdata = 8'(ien);
      8'd5: rdata = 8'(flags);
      8'd6: rdata = top_b[7:0];
      8'd7: rdata = WIDE ? top_b[15:8] : 8'h00;
      8'd8: rdata = cnt[7:0];
      8'd9: rdata = WIDE ? shadow : 8'h00;
      default: begin
        for (int i = 0; i < CHANNELS; i++) begin
          if (off == 8'(10 + 2 * i)) rdata = cmp_b[i][7:0];
          if (WIDE && off == 8'(11 + 2 * i)) rdata = cmp_b[i][15:8];
        end
      end
    endcase
    if (r_en) begin
      dout_n = rdata;
      if (off == 8'd8) shadow_n = cnt[15:8];
    end

    tick    = (presc == scale);
    presc_n = tick ? 16'd0 : presc + 16'd1;
    if (clr_presc || mode_chg) presc_n = 16'd0;

    if (mode_chg) begin
      cnt_n = 16'd0;
      out_n = '0;
`ifdef COUNTER_TIMER_N_UPDOWN_EN
      dir_n = 1'b1;
`endif
    end else if (mode_eff == MODE_IDLE) begin
      cnt_n   = 16'd0;
      out_n   = '0;
`ifdef COUNTER_TIMER_N_UPDOWN_EN
      dir_n   = 1'b1;
`endif
      top_a_n = top_b_n;
      for (int i = 0; i < CHANNELS; i++) cmp_a_n[i] = cmp_b_n[i];
    end else if (tick) begin
      case (mode_eff)
        MODE_CTC, MODE_FPWM: begin
          wrap    = (cnt == top_a);
          nxt     = wrap ? 16'd0 : cnt + 16'd1;
          fset[0] = wrap;
          load    = wrap;
        end
`ifdef COUNTER_TIMER_N_UPDOWN_EN
        MODE_UDPWM: begin
          // Direction reverses at TOP and at 0; TOP=0 pins the counter.
          if (top_a == 16'd0) begin
            up  = 1'b1;
            nxt = 16'd0;
          end else begin
            up  = dir ? (cnt != top_a) : (cnt == 16'd0);
            nxt = up ? cnt + 16'd1 : cnt - 16'd1;
          end
          dir_n   = up;
          fset[0] = (nxt == top_a);
          load    = (nxt == 16'd0);
        end
`endif
        default: ;
      endcase
      cnt_n = nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        fset[i+1] = (nxt == cmp_a[i]);
        out_n[i]  = (mode_eff == MODE_CTC) ? (out[i] ^ (nxt == cmp_a[i])) : (nxt < cmp_a[i]);
      end
      if (load) begin
        top_a_n = top_b_n;
        for (int i = 0; i < CHANNELS; i++) cmp_a_n[i] = cmp_b_n[i];
      end
    end

    // A set in the same cycle as a write-1 clear wins.
    flags_n = (flags & ~fclr) | fset;
    irq_n   = |(flags_n & ien_n);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode   <= MODE_IDLE;
      scale  <= '0;
      presc  <= '0;
      top_a  <= '0;
      top_b  <= '0;
      cnt    <= '0;
      oen    <= '0;
      ien    <= '0;
      flags  <= '0;
      out    <= '0;
      shadow <= '0;
      dout   <= '0;
      irq    <= 1'b0;
`ifdef COUNTER_TIMER_N_UPDOWN_EN
      dir    <= 1'b1;
`endif
      for (int i = 0; i < CHANNELS; i++) begin
        cmp_a[i] <= '0;
        cmp_b[i] <= '0;
      end
    end else begin
      mode   <= mode_n;
      scale  <= scale_n;
      presc  <= presc_n;
      top_a  <= top_a_n;
      top_b  <= top_b_n;
      cnt    <= cnt_n;
      oen    <= oen_n;
      ien    <= ien_n;
      flags  <= flags_n;
      out    <= out_n;
      shadow <= shadow_n;
      dout   <= dout_n;
      irq    <= irq_n;
`ifdef COUNTER_TIMER_N_UPDOWN_EN
      dir    <= dir_n;
`endif
      for (int i = 0; i < CHANNELS; i++) begin
        cmp_a[i] <= cmp_a_n[i];
        cmp_b[i] <= cmp_b_n[i];
      end
    end
  end

endmodule

// File: tb/tb_counter_timer_n.sv
// tb_counter_timer_n: directed self-checking bench for counter_timer_n (WIDTH=16, two channels,
// window at 0x40). Mode 11 expectations follow COUNTER_TIMER_N_UPDOWN_EN.
module tb_counter_timer_n;
  localparam logic [7:0] BASE = 8'h40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic [7:0] address;
  logic       w_en;
  logic       r_en;
  logic [7:0] dout;
  logic [1:0] out;
  logic [1:0] out_en;
  logic       irq;
  logic [7:0] data;
  int         checks = 0;
  int         errors = 0;

  counter_timer_n #(.BASE_ADDRESS(BASE), .WIDTH(16), .CHANNELS(2)) dut (
    .clk(clk), .rst(rst), .din(din), .address(address), .w_en(w_en), .r_en(r_en),
    .dout(dout), .out(out), .out_en(out_en), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bus cycle: drive on the falling edge, release 1ns after the rising edge.
  task automatic cyc(input logic we, input logic re, input logic [7:0] o, input logic [7:0] d);
    @(negedge clk);
    address = 8'(BASE + o);
    din     = d;
    w_en    = we;
    r_en    = re;
    @(posedge clk);
    #1;
    w_en = 1'b0;
    r_en = 1'b0;
  endtask

  task automatic wr(input logic [7:0] o, input logic [7:0] d);
    cyc(1'b1, 1'b0, o, d);
  endtask

  task automatic rd(input logic [7:0] o, output logic [7:0] d);
    cyc(1'b0, 1'b1, o, 8'h00);
    d = dout;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  function automatic int ud_seq(input int k);
    int p;
    p = k % 8;
    return (p <= 4) ? p : 8 - p;
  endfunction

  initial begin
    rst = 1'b0; din = 8'h00; address = 8'h00; w_en = 1'b0; r_en = 1'b0;
    #1;
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_out", 32'(out), 32'h0);
    check("rst_out_en", 32'(out_en), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Register access, unimplemented bits and unmapped offsets.
    wr(8'd1, 8'h12);  rd(8'd1, data);  check("scale_h_rb", 32'(data), 32'h12);
    wr(8'd1, 8'h00);
    wr(8'd2, 8'hFC);  rd(8'd2, data);  check("control_rb", 32'(data), 32'h00);
    wr(8'd3, 8'hFF);  check("out_en_all", 32'(out_en), 32'h3);
    rd(8'd3, data);   check("out_en_rb", 32'(data), 32'h07);
    rd(8'h1F, data);  check("unmapped_rd", 32'(data), 32'h00);
    rd(8'hFF, data);  check("below_base_rd", 32'(data), 32'h00);
    wr(8'd3, 8'h01);

    // Fast PWM, TOP=9 CMP0=3, then CMP0 rewritten to 7 and a set/clear collision.
    wr(8'd0, 8'd0); wr(8'd6, 8'd9); wr(8'd7, 8'd0); wr(8'd10, 8'd3); wr(8'd4, 8'h01);
    wr(8'd2, 8'd2);
    for (int k = 1; k <= 49; k++) begin
      if (k == 26) wr(8'd10, 8'd7);
      else if (k == 41) wr(8'd4, 8'h02);
      else if (k == 47 || k == 48) wr(8'd5, 8'h02);
      else if (k == 49) rd(8'd5, data);
      else idle();
      if (k <= 40) begin
        check("fpwm_out0", 32'(out[0]), 32'((k % 10) < ((k >= 30) ? 7 : 3)));
        check("fpwm_out1_cmp0", 32'(out[1]), 32'h0);
        check("fpwm_top_irq", 32'(irq), 32'(k >= 10));
      end
      if (k == 41) check("match_irq", 32'(irq), 32'h1);
      if (k == 47) check("set_beats_clear", 32'(irq), 32'h1);
      if (k == 48) check("flag_cleared", 32'(irq), 32'h0);
      if (k == 49) check("flags_rb", 32'(data), 32'h05);
    end

    // TOP=0: counter pinned at 0, top flag on every tick.
    wr(8'd2, 8'd0);   check("idle_out", 32'(out), 32'h0);
    rd(8'd8, data);   check("idle_cnt", 32'(data), 32'h00);
    wr(8'd6, 8'd0); wr(8'd5, 8'h07); wr(8'd4, 8'h01);
    check("top0_irq_pre", 32'(irq), 32'h0);
    wr(8'd2, 8'd2);
    idle();           check("top0_irq_tick", 32'(irq), 32'h1);
    wr(8'd5, 8'h01);  check("top0_irq_reset", 32'(irq), 32'h1);
    rd(8'd8, data);   check("top0_cnt", 32'(data), 32'h00);

    // CTC, SCALE=1, TOP=0x0100: coherent 16-bit reads and output toggles.
    wr(8'd2, 8'd0); wr(8'd0, 8'd1); wr(8'd6, 8'h00); wr(8'd7, 8'h01);
    wr(8'd2, 8'd1);
    for (int k = 1; k <= 517; k++) begin
      if (k == 511 || k == 513 || k == 517) rd(8'd8, data);
      else if (k == 512 || k == 514) rd(8'd9, data);
      else idle();
      if (k == 511) check("ctc_cnt_l_ff", 32'(data), 32'hFF);
      if (k == 512) check("ctc_cnt_h_00", 32'(data), 32'h00);
      if (k == 513) check("ctc_cnt_l_00", 32'(data), 32'h00);
      if (k == 514) check("ctc_cnt_h_01", 32'(data), 32'h01);
      if (k == 517) check("ctc_after_wrap", 32'(data), 32'h01);
      if (k == 13)  check("ctc_out0_pre", 32'(out[0]), 32'h0);
      if (k == 14)  check("ctc_out0_tog", 32'(out[0]), 32'h1);
      if (k == 513) check("ctc_out1_pre", 32'(out[1]), 32'h0);
      if (k == 514) check("ctc_out1_tog", 32'(out[1]), 32'h1);
    end

    // Mode 11, TOP=4, CMP1=2 (CMP0=7 is above TOP).
    wr(8'd2, 8'd0); wr(8'd0, 8'd0); wr(8'd6, 8'd4); wr(8'd7, 8'd0); wr(8'd12, 8'd2);
    wr(8'd5, 8'h07); wr(8'd4, 8'h01);
    wr(8'd2, 8'd3);
    for (int k = 1; k <= 16; k++) begin
      if (k == 6) wr(8'd5, 8'h01);
      else rd(8'd8, data);
`ifdef COUNTER_TIMER_N_UPDOWN_EN
      if (k != 6) check("ud_cnt", 32'(data), 32'(ud_seq(k - 1)));
      check("ud_out1", 32'(out[1]), 32'(ud_seq(k) < 2));
      check("ud_out0_const", 32'(out[0]), 32'h1);
      check("ud_top_irq", 32'(irq), 32'((k >= 4 && k < 6) || k >= 12));
`else
      if (k != 6) check("m11_idle_cnt", 32'(data), 32'h00);
      check("m11_idle_out", 32'(out), 32'h0);
      check("m11_idle_irq", 32'(irq), 32'h0);
`endif
    end

    // Asynchronous reset mid-count.
    wr(8'd2, 8'd0); wr(8'd6, 8'd9); wr(8'd10, 8'd5); wr(8'd12, 8'd1);
    wr(8'd3, 8'h03); wr(8'd4, 8'h07); wr(8'd5, 8'h07);
    wr(8'd2, 8'd2);
    idle(); idle();
    rd(8'd3, data);
    check("pre_rst_dout", 32'(dout), 32'h03);
    check("pre_rst_out", 32'(out), 32'h1);
    check("pre_rst_irq", 32'(irq), 32'h1);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("async_dout", 32'(dout), 32'h0);
    check("async_out", 32'(out), 32'h0);
    check("async_out_en", 32'(out_en), 32'h0);
    check("async_irq", 32'(irq), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rd(8'd2, data);   check("post_rst_mode", 32'(data), 32'h00);
    rd(8'd8, data);   check("post_rst_cnt", 32'(data), 32'h00);
    rd(8'd6, data);   check("post_rst_top", 32'(data), 32'h00);
    check("post_rst_out", 32'(out), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_timer_n.md
COUNTER_TIMER_N -- requirements
Module: counter_timer_n

Interface
REQ-001 Parameter BASE_ADDRESS, default 8'h00, is the first byte address of the register window.
REQ-002 Parameter WIDTH, default 8, is the counter/TOP/compare width; only 8 or 16 are legal.
REQ-003 Parameter CHANNELS, default 2, is the number of compare/output channels; only 1..4 are legal.
REQ-004 clk  in  1  is the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  is the reset: asynchronous, active-low.
REQ-006 din  in  8  carries bus write data.
REQ-007 address  in  8  carries the bus byte address.
REQ-008 w_en  in  1  is the write strobe.
REQ-009 r_en  in  1  is the read strobe.
REQ-010 dout  out  8  is registered read data.
REQ-011 out  out  CHANNELS  carries the per-channel waveform outputs.
REQ-012 out_en  out  CHANNELS  carries the per-channel pad enables, equal to OUT_EN[CHANNELS-1:0].
REQ-013 irq  out  1  is the level interrupt, equal to the OR of (FLAGS AND IRQ_EN).

Function
REQ-014 The register map, as offsets from BASE_ADDRESS, SHALL be:
- 0 SCALE_L, 1 SCALE_H, 2 CONTROL[1:0]=mode
- 3 OUT_EN, 4 IRQ_EN, 5 FLAGS
- 6 TOP_L, 7 TOP_H, 8 CNT_L, 9 CNT_H (read-only)
- 10+2i CMPi_L, 11+2i CMPi_H
- In FLAGS, IRQ_EN and OUT_EN, bit0 = top and bit1+i = match i.
REQ-015 Reads SHALL have one-cycle latency; unmapped offsets, unimplemented bits and _H bytes when WIDTH=8 SHALL read 0, and writes to them SHALL be ignored.
REQ-016 A read of CNT_L SHALL latch counter[WIDTH-1:8] into a shadow register, and a read of CNT_H SHALL return that shadow.
REQ-017 The prescaler SHALL assert a one-cycle tick every SCALE+1 clocks, and a write to SCALE_L or SCALE_H SHALL clear the prescaler.
REQ-018 The counter SHALL change only on a tick.
REQ-019 TOP and CMPi writes SHALL go to buffers, which are copied to the active registers when the counter wraps to 0 (modes 01/10) or reaches 0 (mode 11); in mode 00 the copy is immediate.
REQ-020 Mode 00 (idle): counter=0, out=0, direction=up, and no flags are set.
REQ-021 Mode 01 (CTC): the counter counts up and goes TOP->0; out[i] toggles on each tick where the counter becomes CMPi.
REQ-022 Mode 10 (fast PWM): the counter counts 0..TOP and wraps; each tick, out[i] <= (next counter < CMPi).
- CMPi=0 gives constant 0.
- CMPi>TOP gives constant 1.
REQ-023 Mode 11 (up-down PWM): the counter counts 0->TOP->0, reversing at TOP and at 0; out[i] follows the same compare rule as mode 10.
REQ-024 With TOP=0, the counter SHALL stay at 0, and the top flag SHALL set on every tick in modes 01, 10 and 11.
REQ-025 The top flag SHALL set on the tick where the counter wraps TOP->0 (modes 01/10) or becomes TOP (mode 11).
REQ-026 Match flag i SHALL set on each tick where the counter becomes CMPi.
REQ-027 FLAGS bits SHALL be sticky and cleared by writing 1; a set and a clear in the same cycle SHALL leave the flag set.
REQ-028 A CONTROL write that changes the mode SHALL clear the counter, prescaler, direction and out in that cycle.

Reset
REQ-029 On rst low, all of the following SHALL be 0 immediately, independent of clk: registers, buffers, prescaler, counter, shadow, dout, out, out_en, irq.
REQ-030 Assertion mid-count SHALL abandon the count, and after deassertion the block SHALL start in mode 00.

Configuration
REQ-031 With macro COUNTER_TIMER_N_UPDOWN_EN defined, mode 11 SHALL behave as in REQ-023.
REQ-032 Without COUNTER_TIMER_N_UPDOWN_EN, mode 11 SHALL behave exactly as mode 00, and no direction state SHALL exist.

Verification
REQ-033 SCALE=0, TOP=9, CMP0=3, mode 10 -> out[0] high 3 ticks and low 7 ticks, repeating every 10 clocks; top flag every 10 clocks.
REQ-034 WIDTH=16, SCALE=1, TOP=0x0100, mode 01 -> counter runs 0..256 at half clock rate; a CNT_L then CNT_H read returns a coherent 16-bit value.
REQ-035 Mode 11, TOP=4, CMP1=2 -> counter sequence 0,1,2,3,4,3,2,1,0; out[1] high when the counter is 0 or 1; top flag once per 8 ticks.
REQ-036 IRQ_EN=0x02, match0 flag set, write FLAGS=0x02 in the same cycle as a new match -> flag remains 1 and irq stays high.
REQ-037 CMP0 rewritten from 3 to 7 mid-period in mode 10 -> the old duty completes, and the new duty starts after the wrap.
REQ-038 rst pulsed low mid-count without a clock edge -> all outputs 0 immediately; after release, mode 00 and counter 0.
